signed_spatial_mac_pipe: RTL and testbench

- Pipelined, runtime-precision signed dot-product MAC built on the spatial low-precision multiplier fabric.
- Each accepted element pair (a, b) packs several signed lanes. The block multiplies them lane-wise, reduces them to one sum, and accumulates over cfg_len elements into a saturating accumulator.
- Result is returned through a valid/ready output.
- Sits between the operand buffers and the output/writeback buffer of a processing element.

---
 rtl/signed_spatial_mac_pipe.sv | 183 ++++++++++++++++++
 tb/tb_signed_spatial_mac_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_spatial_mac_pipe.sv
// Runtime-precision signed lane dot-product MAC with saturating accumulator.
// Pipe: operand register, lane products, lane reduction, accumulate.
module signed_spatial_mac_pipe #(
    parameter int PRECISION   = 8,
    parameter int L_PRECISION = 2,
    parameter int IN_WIDTH    = (PRECISION / L_PRECISION) * PRECISION,
    parameter int ACC_WIDTH   = 32,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           cfg_a_prec,
    input  logic [1:0]           cfg_b_prec,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  a,
    input  logic [IN_WIDTH-1:0]  b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 busy
);

    localparam int MAXL  = IN_WIDTH / L_PRECISION;
    localparam int PW    = 2 * PRECISION;
    localparam int SUM_W = PW + $clog2(MAXL);
    localparam int EXT_W = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;
    localparam int LSH   = $clog2(PRECISION / L_PRECISION);
    localparam logic signed [EXT_W-1:0] MAXV = EXT_W'({(ACC_WIDTH-1){1'b1}});
    localparam logic signed [EXT_W-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_e;

    // Lane width is PRECISION >> sh; lane idx sign-extended to PRECISION bits.
    function automatic logic signed [PRECISION-1:0] lane_f(
        input logic [IN_WIDTH-1:0] v,
        input logic [1:0]          sh,
        input int                  idx
    );
        logic [IN_WIDTH-1:0]         s;
        logic signed [PRECISION-1:0] t;
        int                          w;
        w = PRECISION >> sh;
        s = v >> (idx * w);
        t = s[PRECISION-1:0];
        t = (t <<< (PRECISION - w)) >>> (PRECISION - w);
        return t;
    endfunction

    function automatic logic [1:0] clamp_sh(input logic [1:0] code);
        logic [1:0] s;
        s = (code == 2'd3) ? 2'd0 : code;
        if ((PRECISION >> s) < L_PRECISION) s = 2'(LSH);
        return s;
    endfunction

    state_e                       state_q, state_d;
    logic [1:0]                   sha_q, sha_d, shb_q, shb_d, shmin;
    logic [LEN_WIDTH-1:0]         len_q, len_d, cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, out_q, out_d, acc_new;
    logic                         sat_q, sat_d;
    logic                         v1_q, v2_q, v3_q, xfer;
    logic [IN_WIDTH-1:0]          a_q, b_q;
    logic signed [PW-1:0]         p_q [MAXL];
    logic signed [PW-1:0]         p_d [MAXL];
    logic signed [SUM_W-1:0]      sum_q, sum_d;
    logic signed [EXT_W-1:0]      acc_ext;
    logic                         ovf_hi, ovf_lo;

    assign in_ready  = (state_q == ACCUM) && (cnt_q < len_q);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;
    assign out_sat   = sat_q;
    assign xfer      = in_valid & in_ready;
    assign shmin     = (sha_q < shb_q) ? sha_q : shb_q;

    always_comb begin
        for (int i = 0; i < MAXL; i++) begin
            p_d[i] = '0;
            if ((i * (PRECISION >> shmin)) < IN_WIDTH)
                p_d[i] = PW'(lane_f(a_q, sha_q, i)) * PW'(lane_f(b_q, shb_q, i));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < MAXL; i++) sum_d = sum_d + SUM_W'(p_q[i]);
    end

    assign acc_ext = EXT_W'(acc_q) + EXT_W'(sum_q);
    assign ovf_hi  = acc_ext > MAXV;
    assign ovf_lo  = acc_ext < MINV;
    assign acc_new = ovf_hi ? MAXV[ACC_WIDTH-1:0] :
                     ovf_lo ? MINV[ACC_WIDTH-1:0] : acc_ext[ACC_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            for (int i = 0; i < MAXL; i++) p_q[i] <= '0;
        end else begin
            v1_q <= xfer;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (xfer) begin
                a_q <= a;
                b_q <= b;
            end
            if (v1_q) p_q <= p_d;
            if (v2_q) sum_q <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        out_d   = out_q;
        if (v3_q) begin
            acc_d = acc_new;
            if (ovf_hi || ovf_lo) sat_d = 1'b1;
        end
        if (xfer) cnt_d = cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start && cfg_len != '0) begin
                    sha_d   = clamp_sh(cfg_a_prec);
                    shb_d   = clamp_sh(cfg_b_prec);
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: if (xfer && cnt_d == len_q) state_d = DRAIN;
            // Final accumulate lands this edge once the earlier stages are empty.
            DRAIN: begin
                if (!v1_q && !v2_q) begin
                    out_d   = acc_d;
                    state_d = OUTPUT;
                end
            end
            OUTPUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_signed_spatial_mac_pipe.sv
// Directed bench for signed_spatial_mac_pipe (32-bit and 16-bit accumulators).
module tb_signed_spatial_mac_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cfg_a_prec = '0;
    logic [1:0]  cfg_b_prec = '0;
    logic [15:0] cfg_len = '0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_sat, busy;
    logic [31:0] out_data;
    logic        in_ready16, out_valid16, out_sat16, busy16;
    logic [15:0] out_data16;

    int cyc = 0;
    int xfers = 0;
    int n_chk = 0;
    int n_fail = 0;

    signed_spatial_mac_pipe dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_a_prec(cfg_a_prec), .cfg_b_prec(cfg_b_prec), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    signed_spatial_mac_pipe #(.ACC_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start),
        .cfg_a_prec(cfg_a_prec), .cfg_b_prec(cfg_b_prec), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
        .out_sat(out_sat16), .busy(busy16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) xfers <= xfers + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [1:0] pa, input logic [1:0] pb,
                             input logic [15:0] len);
        start = 1'b1;
        cfg_a_prec = pa;
        cfg_b_prec = pb;
        cfg_len = len;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        output int t);
        in_valid = 1'b1;
        a = av;
        b = bv;
        for (int k = 0; k < 20 && !in_ready; k++) step();
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        t = cyc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t);
        for (int k = 0; k < 50 && !out_valid; k++) step();
        check("out_valid_wait", {31'b0, out_valid}, 32'd1);
        t = cyc;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_out_valid", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int ta, to, x0;
        logic [31:0] r;

        step();
        step();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_sat", {31'b0, out_sat}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        reset = 1'b0;
        step();

        // 8x8, len 1: 12 - 14 - 5 + 16384
        start_job(2'd0, 2'd0, 16'd1);
        send(32'h8005FE03, 32'h80FF0704, ta);
        wait_out(to);
        check("t1_latency", 32'(to - ta), 32'd4);
        check("t1_data", out_data, 32'd16377);
        check("t1_sat", {31'b0, out_sat}, 32'd0);
        release_out();

        // 2x2, len 3, gaps: 3 * (16 * -1)
        x0 = xfers;
        start_job(2'd2, 2'd2, 16'd3);
        for (int e = 0; e < 3; e++) begin
            send(32'h55555555, 32'hFFFFFFFF, ta);
            if (e < 2) begin
                step();
                step();
            end
        end
        check("t2_ready_low", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        wait_out(to);
        in_valid = 1'b0;
        check("t2_xfers", 32'(xfers - x0), 32'd3);
        check("t2_data", out_data, 32'hFFFFFFD0);
        check("t2_sat", {31'b0, out_sat}, 32'd0);
        release_out();

        // 8x2 mixed: upper twelve 2-bit b lanes ignored
        r = $urandom();
        start_job(2'd0, 2'd2, 16'd1);
        send(32'h0A0A0A0A, {r[31:8], 8'h6D}, ta);
        wait_out(to);
        check("t3_data", out_data, 32'hFFFFFFF6);
        release_out();

        // Saturation on the 16-bit accumulator instance
        start_job(2'd0, 2'd0, 16'd2);
        send(32'h80808080, 32'h80808080, ta);
        send(32'h80808080, 32'h80808080, ta);
        wait_out(to);
        check("t4_data32", out_data, 32'h00020000);
        check("t4_sat32", {31'b0, out_sat}, 32'd0);
        check("t4_valid16", {31'b0, out_valid16}, 32'd1);
        check("t4_data16", {16'b0, out_data16}, 32'h00007FFF);
        check("t4_sat16", {31'b0, out_sat16}, 32'd1);
        release_out();
        start_job(2'd0, 2'd0, 16'd1);
        send(32'h0, 32'h0, ta);
        wait_out(to);
        check("t4b_data32", out_data, 32'd0);
        check("t4b_data16", {16'b0, out_data16}, 32'd0);
        check("t4b_sat16", {31'b0, out_sat16}, 32'd0);
        release_out();

        // Backpressure with an ignored start during OUTPUT
        start_job(2'd0, 2'd0, 16'd1);
        send(32'h7F7F7F7F, 32'h7F7F7F7F, ta);
        wait_out(to);
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_valid", {31'b0, out_valid}, 32'd1);
            check("t5_hold_data", out_data, 32'h0000FC04);
            check("t5_hold_busy", {31'b0, busy}, 32'd1);
            start = (k == 2);
            cfg_a_prec = 2'd2;
            cfg_len = 16'd5;
            step();
        end
        start = 1'b0;
        check("t5_after_start", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        start = 1'b1;
        step();
        out_ready = 1'b0;
        start = 1'b0;
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_valid", {31'b0, out_valid}, 32'd0);
        check("t5_retain", out_data, 32'h0000FC04);
        step();
        check("t5_still_idle", {31'b0, busy}, 32'd0);

        // Reset mid-ACCUM after two of four elements
        start_job(2'd0, 2'd0, 16'd4);
        send(32'h01010101, 32'h02020202, ta);
        send(32'h01010101, 32'h02020202, ta);
        reset = 1'b1;
        #1;
        check("t6_in_ready", {31'b0, in_ready}, 32'd0);
        check("t6_out_valid", {31'b0, out_valid}, 32'd0);
        check("t6_out_sat", {31'b0, out_sat}, 32'd0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        start_job(2'd0, 2'd0, 16'd1);
        send(32'h01010101, 32'h02020202, ta);
        wait_out(to);
        check("t6_latency", 32'(to - ta), 32'd4);
        check("t6_data", out_data, 32'd8);
        release_out();

        check("sync16", {30'b0, in_ready16, busy16}, {30'b0, in_ready, busy});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
